ym3438_dbg_capture: RTL and testbench

Serial-to-parallel capture block for the chip's debug read chain. The chain's serializer loads a word on a select strobe and shifts it out one bit per c1/c2 cycle. This block deserializes that stream into WIDTH-bit words, tags each word with the operator slot it was loaded in, and presents it to a host-side reader through a valid/ready handshake. It sits between the debug serial output of any generator (phase, envelope, operator) and the test/register-read logic.

---
 rtl/ym3438_dbg_capture.sv | 186 ++++++++++++++++++
 tb/tb_ym3438_dbg_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_dbg_capture.sv
`default_nettype none
// ============================================================================
// Module      : ym3438_dbg_capture
// Description : Deserializer for the debug read chain. A load strobe tags the
//               capture with the current operator slot, the next WIDTH ticks
//               shift in the word LSB first, and the finished word is offered
//               to a host reader through a valid/ready handshake. A word that
//               completes while the previous one is still unread is dropped,
//               and the sticky overrun flag is raised.
// Ports       : MCLK        - master clock, rising edge
//               reset       - synchronous active-high reset
//               c1          - phase-1 enable (unused, alignment only)
//               c2          - phase-2 enable; an edge with c2=1 is a tick
//               dbg_load    - serializer load strobe, sampled on a tick
//               dbg_in      - serial debug bit, sampled on a tick
//               slot_sync   - marks the tick of slot 0
//               word_ready  - host accepts the presented word
//               clr_overrun - clears the overrun flag
//               word_data   - captured word
//               word_slot   - slot number of the load tick
//               word_valid  - word_data/word_slot are valid
//               overrun     - sticky, a completed word was dropped
//               busy        - capture in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ym3438_dbg_capture #(
  parameter int WIDTH  = 10,
  parameter int NSLOTS = 24
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic             c1,
  input  logic             c2,
  input  logic             dbg_load,
  input  logic             dbg_in,
  input  logic             slot_sync,
  input  logic             word_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] word_data,
  output logic [4:0]       word_slot,
  output logic             word_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int               CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [4:0]       C_LAST_SLOT = 5'(NSLOTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_slot;
  logic [4:0]       w_slot_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [4:0]       r_tag;
  logic [WIDTH-1:0] r_word_data;
  logic [4:0]       r_word_slot;
  logic             r_word_valid;
  logic             r_overrun;
  logic             w_tick;
  logic             w_complete;
  logic             w_take;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;
  logic             w_unused;

  // c1 only matters for external alignment checks.
  assign w_unused = c1;

  assign w_tick = c2;

  // The slot number of a tick is the counter value after that tick's update,
  // so the slot_sync tick itself is slot 0 and the tick after it is slot 1.
  always_comb begin
    w_slot_next = r_slot;
    if (slot_sync) begin
      w_slot_next = 5'd0;
    end else if (r_slot == C_LAST_SLOT) begin
      w_slot_next = 5'd0;
    end else begin
      w_slot_next = r_slot + 5'd1;
    end
  end

  // Next-state logic. A load strobe during SHIFT restarts the capture, so it
  // takes priority over completion of the final bit.
  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && dbg_load) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (dbg_load) begin
            w_state_next = ST_SHIFT;
          end else if (r_cnt == C_LAST_BIT) begin
            w_state_next = ST_IDLE;
            w_complete   = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The final bit is merged straight into the output word so the result is
  // presented on the same edge that samples it.
  assign w_word = {dbg_in, r_shift[WIDTH-2:0]};
  assign w_take = w_complete && (!r_word_valid || word_ready);
  assign w_drop = w_complete && r_word_valid && !word_ready;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_slot       <= 5'd0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_tag        <= 5'd0;
      r_word_data  <= '0;
      r_word_slot  <= 5'd0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_tick) begin
        r_slot <= w_slot_next;
      end

      // Capture side: the load tick never samples a data bit.
      if (w_tick && dbg_load) begin
        r_tag   <= w_slot_next;
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_tick && (r_state == ST_SHIFT)) begin
        r_shift[r_cnt] <= dbg_in;
        if (w_complete) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end

      // Host side, evaluated on every edge.
      if (w_take) begin
        r_word_data  <= w_word;
        r_word_slot  <= r_tag;
        r_word_valid <= 1'b1;
      end else if (r_word_valid && word_ready) begin
        r_word_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign word_data  = r_word_data;
  assign word_slot  = r_word_slot;
  assign word_valid = r_word_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_ym3438_dbg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ym3438_dbg_capture
// Description : Self-checking bench for ym3438_dbg_capture. Stimulus pushes
//               the hand-computed word/slot of every word the host should
//               receive; an independent monitor pops and compares on each
//               handshake transfer. Flag and timing checks are made inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ym3438_dbg_capture;

  localparam int WIDTH  = 10;
  localparam int NSLOTS = 24;

  logic             MCLK = 1'b0;
  logic             reset;
  logic             c1;
  logic             c2;
  logic             dbg_load;
  logic             dbg_in;
  logic             slot_sync;
  logic             word_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] word_data;
  logic [4:0]       word_slot;
  logic             word_valid;
  logic             overrun;
  logic             busy;

  typedef struct packed {
    logic [4:0]       s;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  int   popped = 0;

  ym3438_dbg_capture #(.WIDTH(WIDTH), .NSLOTS(NSLOTS)) dut (
    .MCLK        (MCLK),
    .reset       (reset),
    .c1          (c1),
    .c2          (c2),
    .dbg_load    (dbg_load),
    .dbg_in      (dbg_in),
    .slot_sync   (slot_sync),
    .word_ready  (word_ready),
    .clr_overrun (clr_overrun),
    .word_data   (word_data),
    .word_slot   (word_slot),
    .word_valid  (word_valid),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One c1/c2 cycle: tick edge with the given inputs, then a non-tick edge.
  task automatic tick(input logic ld, input logic b, input logic sy);
    @(negedge MCLK);
    c1 = 1'b0; c2 = 1'b1; dbg_load = ld; dbg_in = b; slot_sync = sy;
    @(negedge MCLK);
    c2 = 1'b0; c1 = 1'b1; dbg_load = 1'b0; dbg_in = 1'b0; slot_sync = 1'b0;
  endtask

  task automatic capture(input logic [WIDTH-1:0] w);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) tick(1'b0, w[i], 1'b0);
  endtask

  // Sync tick (slot 0), idle up to slot s-1, load on slot s.
  task automatic capture_at(input int s, input logic [WIDTH-1:0] w);
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 1; i < s; i++) tick(1'b0, 1'b0, 1'b0);
    capture(w);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge MCLK);
  endtask

  // Monitor: a transfer happens on the next edge when valid and ready are
  // both high just before it.
  always @(negedge MCLK) begin
    #4;
    if (!reset && word_valid && word_ready) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got data 0x%0h slot %0d, expected no word", word_data, word_slot);
      end else begin
        mon_e = expq.pop_front();
        check("word", {27'd0, word_slot, word_data}, {27'd0, mon_e.s, mon_e.d});
        popped++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; c1 = 1'b1; c2 = 1'b0; dbg_load = 1'b0; dbg_in = 1'b0;
    slot_sync = 1'b0; word_ready = 1'b0; clr_overrun = 1'b0;
    idle_cycles(3);
    check("rst_data", {22'd0, word_data}, 32'd0);
    check("rst_slot", {27'd0, word_slot}, 32'd0);
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Basic word, slot 5, with latency and busy window.
    expq.push_back('{s: 5'd5, d: 10'h2A5});
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("busy_after_load", {31'd0, busy}, 32'd1);
    for (int i = 0; i < WIDTH - 1; i++) begin
      tick(1'b0, 1'(10'h2A5 >> i), 1'b0);
      check("no_early_valid", {30'd0, word_valid, busy}, 32'd1);
    end
    tick(1'b0, 1'b1, 1'b0);
    check("valid_on_last_bit", {30'd0, word_valid, busy}, 32'd2);
    word_ready = 1'b1;
    idle_cycles(2);
    check("valid_clears", {31'd0, word_valid}, 32'd0);

    // Backpressure and overrun.
    word_ready = 1'b0;
    expq.push_back('{s: 5'd3, d: 10'h155});
    capture_at(3, 10'h155);
    capture(10'h0AA);
    check("bp_data", {22'd0, word_data}, 32'h155);
    check("bp_slot", {27'd0, word_slot}, 32'd3);
    check("bp_overrun", {31'd0, overrun}, 32'd1);
    word_ready = 1'b1;
    idle_cycles(2);
    check("bp_valid_after", {31'd0, word_valid}, 32'd0);
    check("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    idle_cycles(1);
    clr_overrun = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Completion and accept on the same edge.
    word_ready = 1'b0;
    expq.push_back('{s: 5'd2, d: 10'h001});
    expq.push_back('{s: 5'd13, d: 10'h3FF});
    capture_at(2, 10'h001);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) tick(1'b0, 1'b1, 1'b0);
    @(negedge MCLK);
    c1 = 1'b0; c2 = 1'b1; dbg_in = 1'b1; word_ready = 1'b1;
    @(negedge MCLK);
    c2 = 1'b0; c1 = 1'b1; dbg_in = 1'b0; word_ready = 1'b0;
    check("sim_data", {22'd0, word_data}, 32'h3FF);
    check("sim_valid", {31'd0, word_valid}, 32'd1);
    check("sim_overrun", {31'd0, overrun}, 32'd0);
    word_ready = 1'b1;
    idle_cycles(2);

    // Restart mid-word: only the second capture survives.
    expq.push_back('{s: 5'd9, d: 10'h000});
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
    capture(10'h000);
    idle_cycles(6);
    check("restart_one_word", popped, 32'd5);

    // Reset mid-shift with a held word and overrun pending.
    word_ready = 1'b0;
    capture_at(1, 10'h2F0);
    capture(10'h10F);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);
    check("pre_rst_state", {29'd0, word_valid, overrun, busy}, 32'd7);
    reset = 1'b1;
    @(negedge MCLK);
    check("midrst_outputs", {word_data, word_slot, word_valid, overrun, busy}, 32'd0);
    reset = 1'b0;
    word_ready = 1'b1;
    expq.push_back('{s: 5'd3, d: 10'h123});
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    capture(10'h123);
    idle_cycles(2);

    // Slot wrap, then a back-to-back word.
    expq.push_back('{s: 5'd1, d: 10'h3C3});
    expq.push_back('{s: 5'd12, d: 10'h30F});
    capture_at(25, 10'h3C3);
    capture(10'h30F);
    idle_cycles(4);

    check("queue_empty", expq.size(), 32'd0);
    check("words_seen", popped, 32'd8);
    check("final_overrun", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
